// File: rtl/risc_pkg.sv
// Shared types and encodings for the simple RISC controller: instruction field
// positions, opcode/op constants, ALU/shift codes and the sequencing states.
package risc_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_CMP_S
  } ctrl_state_t;

  // Exactly one class bit is set for any instruction word.
  typedef struct packed {
    logic mov_imm;
    logic mov_reg;
    logic alu_rr;
    logic cmp;
    logic mvn;
    logic illegal;
  } instr_cls_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> system/regfile/datapath bundle. master = controller side,
// slave = the surrounding system that feeds instructions and consumes strobes.
interface cpu_controller_if #(parameter int W = 16) ();
  logic         s;
  logic         load;
  logic [W-1:0] in;
  logic         w;
  logic         illegal;
  logic [2:0]   readnum;
  logic [2:0]   writenum;
  logic         write;
  logic         loada;
  logic         loadb;
  logic         loadc;
  logic         loads;
  logic         asel;
  logic         bsel;
  logic         vsel;
  logic [1:0]   shift;
  logic [1:0]   ALUop;
  logic [W-1:0] sximm8;
  logic [W-1:0] sximm5;

  modport master (
    input  s, load, in,
    output w, illegal, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );

  modport slave (
    output s, load, in,
    input  w, illegal, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/cpu_controller_instr_dec.sv
// Purely combinational instruction decode: register fields, sign-extended
// immediates and a one-hot instruction class.
module instr_dec
  import risc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] i_ir,
  output logic [2:0]   o_rn,
  output logic [2:0]   o_rd,
  output logic [2:0]   o_rm,
  output logic [1:0]   o_shift,
  output logic [1:0]   o_aluop,
  output logic [W-1:0] o_sximm8,
  output logic [W-1:0] o_sximm5,
  output instr_cls_t   o_cls
);

  logic [2:0] w_opc;
  logic [1:0] w_op;
  logic       w_is_mov;
  logic       w_is_alu;

  assign w_opc    = i_ir[OPC_HI:OPC_LO];
  assign w_op     = i_ir[OP_HI:OP_LO];
  assign o_rn     = i_ir[RN_HI:RN_LO];
  assign o_rd     = i_ir[RD_HI:RD_LO];
  assign o_rm     = i_ir[RM_HI:RM_LO];
  assign o_shift  = i_ir[SH_HI:SH_LO];
  assign o_aluop  = w_op;
  assign o_sximm8 = {{(W-8){i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5 = {{(W-5){i_ir[4]}}, i_ir[4:0]};

  assign w_is_mov = (w_opc == OPC_MOV);
  assign w_is_alu = (w_opc == OPC_ALU);

  always_comb begin
    o_cls         = '0;
    o_cls.mov_imm = w_is_mov && (w_op == OP_MOV_IMM);
    o_cls.mov_reg = w_is_mov && (w_op == OP_MOV_REG);
    o_cls.alu_rr  = w_is_alu && ((w_op == ALU_ADD) || (w_op == ALU_AND));
    o_cls.cmp     = w_is_alu && (w_op == ALU_CMP);
    o_cls.mvn     = w_is_alu && (w_op == ALU_MVN);
    o_cls.illegal = !(o_cls.mov_imm || o_cls.mov_reg || o_cls.alu_rr ||
                      o_cls.cmp || o_cls.mvn);
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus the Moore sequencer that walks regfile/datapath
// strobes through each instruction's cycles and reports idle on w.
module cpu_controller
  import risc_pkg::*;
#(
  parameter int W = 16
) (
  input logic              clk,
  input logic              reset,
  cpu_controller_if.master bus
);

  ctrl_state_t  r_state;
  ctrl_state_t  w_nxt;
  logic [W-1:0] r_ir;

  logic [2:0]   w_rn, w_rd, w_rm;
  logic [1:0]   w_shift, w_aluop;
  logic [W-1:0] w_sximm8, w_sximm5;
  instr_cls_t   w_cls;

  logic       w_w, w_illegal, w_write, w_loada, w_loadb, w_loadc, w_loads;
  logic       w_asel, w_vsel;
  logic [2:0] w_readnum, w_writenum;

  instr_dec #(.W(W)) u_dec (
    .i_ir     (r_ir),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_rm     (w_rm),
    .o_shift  (w_shift),
    .o_aluop  (w_aluop),
    .o_sximm8 (w_sximm8),
    .o_sximm5 (w_sximm5),
    .o_cls    (w_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_WAIT && bus.load) r_ir <= bus.in;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_w        = 1'b0;
    w_illegal  = 1'b0;
    w_readnum  = 3'd0;
    w_writenum = 3'd0;
    w_write    = 1'b0;
    w_loada    = 1'b0;
    w_loadb    = 1'b0;
    w_loadc    = 1'b0;
    w_loads    = 1'b0;
    w_asel     = 1'b0;
    w_vsel     = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_w = 1'b1;
        if (bus.s) w_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_nxt     = S_WAIT;
        w_illegal = w_cls.illegal;
        if (w_cls.mov_imm)                   w_nxt = S_WRITE_IMM;
        else if (w_cls.alu_rr || w_cls.cmp)  w_nxt = S_GET_A;
        else if (w_cls.mov_reg || w_cls.mvn) w_nxt = S_GET_B;
      end
      S_WRITE_IMM: begin
        w_writenum = w_rn;
        w_vsel     = 1'b1;
        w_write    = 1'b1;
        w_nxt      = S_WAIT;
      end
      S_GET_A: begin
        w_readnum = w_rn;
        w_loada   = 1'b1;
        w_nxt     = S_GET_B;
      end
      S_GET_B: begin
        w_readnum = w_rm;
        w_loadb   = 1'b1;
        w_nxt     = w_cls.cmp ? S_CMP_S : S_ALU;
      end
      // MOV reg and MVN ignore A: the ALU sees 0 on that side.
      S_ALU: begin
        w_loadc = 1'b1;
        w_asel  = w_cls.mov_reg || w_cls.mvn;
        w_nxt   = S_WRITE_REG;
      end
      S_WRITE_REG: begin
        w_writenum = w_rd;
        w_write    = 1'b1;
        w_nxt      = S_WAIT;
      end
      S_CMP_S: begin
        w_loads = 1'b1;
        w_nxt   = S_WAIT;
      end
      default: w_nxt = S_WAIT;
    endcase
  end

  // Reset masks every commit strobe so an aborted instruction cannot write.
  assign bus.write    = w_write   & ~reset;
  assign bus.loada    = w_loada   & ~reset;
  assign bus.loadb    = w_loadb   & ~reset;
  assign bus.loadc    = w_loadc   & ~reset;
  assign bus.loads    = w_loads   & ~reset;
  assign bus.illegal  = w_illegal & ~reset;
  assign bus.w        = w_w;
  assign bus.readnum  = w_readnum;
  assign bus.writenum = w_writenum;
  assign bus.asel     = w_asel;
  assign bus.bsel     = 1'b0;
  assign bus.vsel     = w_vsel;
  assign bus.shift    = w_shift;
  assign bus.ALUop    = w_aluop;
  assign bus.sximm8   = w_sximm8;
  assign bus.sximm5   = w_sximm5;

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction register, decoder and sequencing FSM for the simple RISC machine. Sits directly upstream of the register file and datapath. Latches a 16-bit instruction, decodes its fields, and steps the regfile (`readnum`, `writenum`, `write`) and datapath load/select strobes through the cycles each instruction needs. Signals idle/ready to the surrounding system on `w`.

## Interface
- `W`, default 16: instruction and immediate width.
- `clk` in, 1 bit: single clock; all state updates on its rising edge.
- `reset` in, 1 bit: synchronous, active-high.
- `s` in, 1 bit: start; sampled only in WAIT.
- `load` in, 1 bit: instruction register enable; honoured only in WAIT.
- `in` in, W bits: instruction word.
- `w` out, 1 bit: 1 in WAIT, ready for the next instruction.
- `illegal` out, 1 bit: one-cycle pulse when an unsupported encoding is decoded.
- `readnum` out, 3 bits: regfile read address.
- `writenum` out, 3 bits: regfile write address.
- `write` out, 1 bit: regfile write enable.
- `loada`, `loadb`, `loadc`, `loads` out, 1 bit each: datapath register enables for A, B, C and status.
- `asel` out, 1 bit: 1 selects 0 instead of A as the ALU input.
- `bsel` out, 1 bit: 1 selects `sximm5` instead of the shifted B.
- `vsel` out, 1 bit: regfile write data; 0 = C, 1 = `sximm8`.
- `shift` out, 2 bits: IR[4:3].
- `ALUop` out, 2 bits: IR[12:11].
- `sximm8` out, W bits: sign-extended IR[7:0].
- `sximm5` out, W bits: sign-extended IR[4:0].

## Operation
- IR fields:
  - opcode = IR[15:13]; op = IR[12:11]
  - Rn = IR[10:8]; Rd = IR[7:5]; Rm = IR[2:0]
- Supported encodings:
  - MOV imm: 110/10
  - MOV reg: 110/00
  - ADD: 101/00; CMP: 101/01; AND: 101/10; MVN: 101/11
  - Everything else is illegal.
- IR updates to `in` when `load`=1 and state=WAIT. Otherwise it holds.
- FSM states and outputs. Outputs not listed are 0, and `readnum`/`writenum` are 0.
  - WAIT: `w`=1.
  - DECODE: no strobes.
  - WRITE_IMM: `writenum`=Rn, `vsel`=1, `write`=1.
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - ALU: `loadc`=1. `asel`=1 for MOV reg and MVN.
  - WRITE_REG: `writenum`=Rd, `vsel`=0, `write`=1.
  - CMP_S: `loads`=1.
- Transitions:
  - WAIT → DECODE when `s`=1.
  - DECODE → WRITE_IMM for MOV imm.
  - DECODE → GET_A for ADD, AND and CMP.
  - DECODE → GET_B for MOV reg and MVN.
  - DECODE → WAIT for illegal; `illegal`=1 during that DECODE cycle.
  - GET_A → GET_B.
  - GET_B → CMP_S for CMP; otherwise → ALU.
  - ALU → WRITE_REG.
  - WRITE_IMM, WRITE_REG, CMP_S → WAIT.
- `shift`, `ALUop`, `sximm8` and `sximm5` are driven continuously from the IR.
- `bsel` is always 0; it is reserved for future memory instructions.

## Timing
- Reset:
  - state=WAIT, IR=0.
  - Hence `w`=1, `sximm8`=`sximm5`=0, `ALUop`=`shift`=0.
  - All strobes and `illegal` are 0.
- While `reset`=1, `write`, `loada`, `loadb`, `loadc`, `loads` and `illegal` are forced to 0 combinationally. Reset mid-instruction therefore never commits a partial write.
- `s` and `load` high in the same WAIT cycle: IR captures `in`, and DECODE uses the new IR.
- All strobes are Moore outputs, registered into the regfile/datapath at the edge ending the state.
- `s` sampled at edge k, cycle numbering:
  - MOV imm: WRITE_IMM in cycle k+2; `w`=1 in cycle k+3.
  - ADD/AND: ALU in k+4, WRITE_REG in k+5; `w`=1 in k+6.
  - MOV reg/MVN: ALU in k+3, WRITE_REG in k+4; `w`=1 in k+5.
  - CMP: CMP_S in k+4; `w`=1 in k+5.
  - Illegal: `illegal` in k+1; `w`=1 in k+2.
- `s` outside WAIT is ignored. `s` held high re-launches the next instruction the cycle after returning to WAIT.

## Structure
- Package `risc_pkg` holds:
  - state enum `ctrl_state_t`;
  - opcode/op constants;
  - ALUop and shift constants;
  - field-position localparams.
- One combinational sub-module, `instr_dec`: maps IR to fields, sign extensions and instruction class (`mov_imm`, `mov_reg`, `alu_rr`, `cmp`, `mvn`, `illegal`).
- The FSM and IR remain in `cpu_controller`.

## Test plan
- Reset, then `load`+`s` with 0xD007 (MOV R0,#7) → cycle k+2: `write`=1, `writenum`=0, `vsel`=1, `sximm8`=0x0007; `w`=1 at k+3.
- 0xD1FE (MOV R1,#-2) → `sximm8`=0xFFFE, `writenum`=1.
- 0xA148 (ADD R2,R1,R0 LSL) → responses:
  - GET_A: `readnum`=1, `loada`=1.
  - GET_B: `readnum`=0, `loadb`=1, `shift`=01.
  - ALU: `loadc`=1, `ALUop`=00.
  - WRITE_REG: `writenum`=2, `write`=1; `w` back at k+6.
- 0xA801 (CMP R0,R1) → `loads`=1 in k+4, never `write`; 0xC072 (MOV R3,R2 LSR) → `asel`=1 in ALU, `writenum`=3.
- 0xE000 → `illegal` pulse in k+1, no strobes, `w`=1 at k+2.
- ADD with `reset` asserted during GET_B → WAIT next cycle, `write` never asserted, IR=0; `load` pulsed outside WAIT leaves IR unchanged.
